fifo_ptr_ctrl: RTL
==================

Name: fifo_ptr_ctrl

Overview:
Parametrised single-clock FIFO pointer controller, generalising the single write-pointer block into a full write/read pointer pair. It generates the RAM write and read addresses and enables, and the status flags full, empty, almost_full and almost_empty. It also outputs the fill level and sticky overflow/underflow error flags. It sits between the producer/consumer handshake and the dual-port FIFO RAM in the data path.

Parameters:
ADDR_W, 10, address width; DEPTH = 2**ADDR_W entries.
AFULL_THRESH, 2**ADDR_W - 2, almost_full asserts when fill_level >= this value.
AEMPTY_THRESH, 2, almost_empty asserts when fill_level <= this value.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high; one clock, rising edge.
clr  input  1  synchronous flush; same effect as rst on pointers, fill level and sticky flags.
wr  input  1  producer write request.
rd  input  1  consumer read request.
wptr  output  ADDR_W  RAM write address.
rptr  output  ADDR_W  RAM read address.
fifo_we  output  1  RAM write enable; this is the accepted write.
fifo_re  output  1  RAM read enable; this is the accepted read.
fifo_full  output  1  fill_level == DEPTH.
fifo_empty  output  1  fill_level == 0.
almost_full  output  1  fill_level >= AFULL_THRESH.
almost_empty  output  1  fill_level <= AEMPTY_THRESH.
fill_level  output  ADDR_W+1  number of stored entries, 0..DEPTH.
overflow  output  1  sticky: a write was attempted while full.
underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Pointer format: internal write and read pointers are ADDR_W+1 bits wide; the MSB is a wrap bit. wptr and rptr are the low ADDR_W bits.
- Enables (combinational from registered state and inputs):
  - fifo_we = wr & ~fifo_full & ~clr.
  - fifo_re = rd & ~fifo_empty & ~clr.
- Pointer update: on a clock edge, each pointer increments by 1 when its enable is high. The low bits wrap from DEPTH-1 to 0 and the wrap bit toggles.
- Status decode (combinational from the registered pointers):
  - fifo_empty when the pointers are equal.
  - fifo_full when the low bits are equal and the wrap bits differ.
  - fill_level = wptr_int - rptr_int, modulo 2**(ADDR_W+1).
  - Flags therefore reflect an accepted write/read one cycle after the enable.
- Simultaneous wr and rd:
  - Neither full nor empty: both are accepted and fill_level is unchanged.
  - Full: the read is accepted and the write is rejected.
  - Empty: the write is accepted and the read is rejected.
  - No bypass of either rule.
- Sticky errors:
  - overflow is set at the edge after any cycle with wr & fifo_full & ~clr.
  - underflow is set at the edge after any cycle with rd & fifo_empty & ~clr.
  - Both hold until rst or clr.
- Reset values (rst high at an edge): pointers 0, wptr=0, rptr=0, fill_level=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Reset mid-operation: rst overrides any simultaneous wr/rd and discards all contents. The enables are not masked by rst in the same cycle, so the RAM may be written once; this is harmless because the pointers are cleared.
- clr: identical end state to rst. clr masks fifo_we/fifo_re in its own cycle. rst has priority when both are high.
- Legality: parameters must satisfy 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH; enforced by an elaboration-time check.
- No other state and no state machine beyond the two pointer counters and two sticky bits.

Decomposition:
- Shared package fifo_pkg holds:
  - the ADDR_W default;
  - a helper function computing the default thresholds;
  - the pointer-width constant ADDR_W+1.
- One sub-module, fifo_ptr_cnt: an (ADDR_W+1)-bit wrap counter with clk, rst, clr and en inputs. It is instantiated twice, once for write and once for read.
- Flag decode and sticky bits stay in the top level.

Test Plan:
All scenarios use ADDR_W=2 (DEPTH=4), AFULL_THRESH=3, AEMPTY_THRESH=1.
1. Reset then idle: all outputs at their reset values; fifo_empty=1, almost_empty=1, fill_level=0 for 5 cycles.
2. Fill: wr=1 for 4 cycles.
   - wptr steps 0,1,2,3 then wraps to 0.
   - almost_full rises when fill_level=3; fifo_full=1 at fill_level=4.
   - A 5th wr gives fifo_we=0, wptr holds at 0 and overflow=1 from the next cycle.
3. Drain: from full, rd=1 for 5 cycles.
   - rptr 0..3 then wraps to 0; fifo_empty=1 after 4 reads.
   - The 5th read gives fifo_re=0 and sets underflow=1; underflow stays 1 until clr.
4. Simultaneous access:
   - At fill_level=2, wr=rd=1 for 6 cycles: both enables high every cycle and fill_level stays 2 while the pointers wrap.
   - At full, wr=rd=1: fifo_re=1, fifo_we=0, fill_level becomes 3.
   - At empty, wr=rd=1: fifo_we=1, fifo_re=0, fill_level becomes 1.
5. Flush and reset priority:
   - At fill_level=3 with overflow=1, clr=1 with wr=1: fifo_we=0; the next cycle shows pointers 0, fill_level=0, overflow=0.
   - rst=1 with clr=0 and wr=1 mid-fill gives the same end state.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO pointer controller.
package fifo_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  // Pointer carries one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_width(ADDR_W_DEF);

  function automatic int unsigned afull_default(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd2;
  endfunction

  function automatic int unsigned aempty_default();
    return 2;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap counter for one FIFO pointer; the MSB toggles each time the address wraps.
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [PTR_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: RAM addresses/enables, status flags,
// fill level and sticky overflow/underflow.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned AFULL_THRESH  = afull_default(ADDR_W),
  parameter int unsigned AEMPTY_THRESH = aempty_default()
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic              rd,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic              fifo_we,
  output logic              fifo_re,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = ptr_width(ADDR_W);
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  generate
    if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_bad_thresh
      $error("fifo_ptr_ctrl: thresholds must satisfy AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
  endgenerate

  logic [PTR_W-1:0] wptr_int;
  logic [PTR_W-1:0] rptr_int;

  fifo_ptr_cnt #(.PTR_W(PTR_W)) u_wcnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (fifo_we),
    .cnt (wptr_int)
  );

  fifo_ptr_cnt #(.PTR_W(PTR_W)) u_rcnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (fifo_re),
    .cnt (rptr_int)
  );

  assign wptr = wptr_int[ADDR_W-1:0];
  assign rptr = rptr_int[ADDR_W-1:0];

  // Full/empty differ only in the wrap bit: equal addresses, same or opposite lap.
  assign fifo_empty   = (wptr_int == rptr_int);
  assign fifo_full    = (wptr_int[ADDR_W-1:0] == rptr_int[ADDR_W-1:0]) &&
                        (wptr_int[ADDR_W] != rptr_int[ADDR_W]);
  assign fill_level   = wptr_int - rptr_int;
  assign almost_full  = (fill_level >= PTR_W'(AFULL_THRESH));
  assign almost_empty = (fill_level <= PTR_W'(AEMPTY_THRESH));

  assign fifo_we = wr & ~fifo_full & ~clr;
  assign fifo_re = rd & ~fifo_empty & ~clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (wr & fifo_full);
      underflow <= underflow | (rd & fifo_empty);
    end
  end

endmodule
